// File: rtl/shift_sequencer.sv
// Command sequencer for the 4-bit universal shift register. It turns load/shift/rotate
// commands into per-cycle mode-select, parallel-data and serial-fill drive.
module shift_sequencer #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic             serial_in,
  input  logic [WIDTH-1:0] A_fb,
  output logic [1:0]       s,
  output logic [WIDTH-1:0] I,
  output logic             S_l,
  output logic             S_r,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;
  typedef enum logic [2:0] {
    OP_LOAD = 3'd0,
    OP_SHL  = 3'd1,
    OP_SHR  = 3'd2,
    OP_ROTL = 3'd3,
    OP_ROTR = 3'd4
  } op_t;

  state_t           state, state_nx;
  logic [2:0]       op;
  logic [WIDTH-1:0] data;
  logic [CNT_W-1:0] cnt;
  logic             err_q;
  logic             accept;
  logic             illegal;
  logic             unused_fb;

  assign accept    = cmd_valid && (state == IDLE);
  assign illegal   = (cmd_op > 3'd4);
  assign unused_fb = ^A_fb;

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state <= IDLE;
      op    <= '0;
      data  <= '0;
      cnt   <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_nx;
      err_q <= accept && illegal;
      if (accept) begin
        op   <= cmd_op;
        data <= cmd_data;
        cnt  <= cmd_count;
      end else if (state == SHIFT) begin
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (accept && !illegal) begin
          if (cmd_op == OP_LOAD)              state_nx = LOAD;
          else if (cmd_count == '0)           state_nx = DONE;
          else                                state_nx = SHIFT;
        end
      end
      LOAD:    state_nx = DONE;
      SHIFT:   if (cnt == CNT_W'(1)) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Rotates feed the register's own end bit back in, so S_l/S_r depend live on A_fb.
  always_comb begin
    s   = 2'b11;
    I   = '0;
    S_l = 1'b0;
    S_r = 1'b0;
    if (state == LOAD) begin
      s = 2'b00;
      I = data;
    end else if (state == SHIFT) begin
      case (op)
        OP_SHL:  begin s = 2'b01; S_l = serial_in;    end
        OP_ROTL: begin s = 2'b01; S_l = A_fb[WIDTH-1]; end
        OP_SHR:  begin s = 2'b10; S_r = serial_in;    end
        OP_ROTR: begin s = 2'b10; S_r = A_fb[0];      end
        default: s = 2'b11;
      endcase
    end
  end

  assign cmd_ready = (state == IDLE);
  assign busy      = (state == LOAD) || (state == SHIFT);
  assign done      = (state == DONE);
  assign err       = err_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench: the sequencer drives a behavioural 4-bit universal shift register
// whose output A feeds back to A_fb; expected values are hand-computed per cycle.
module tb_shift_sequencer;

  logic       clk = 1'b0;
  logic       clear;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [3:0] cmd_data;
  logic [2:0] cmd_count;
  logic       serial_in;
  logic [3:0] a_reg = 4'b0000;
  logic [1:0] s;
  logic [3:0] I;
  logic       S_l, S_r, busy, done, err;

  int n_cmp = 0;
  int n_err = 0;

  shift_sequencer #(.WIDTH(4), .CNT_W(3)) dut (
    .clk(clk), .clear(clear), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_count(cmd_count),
    .serial_in(serial_in), .A_fb(a_reg), .s(s), .I(I), .S_l(S_l), .S_r(S_r),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    case (s)
      2'b00:   a_reg <= I;
      2'b01:   a_reg <= {a_reg[2:0], S_l};
      2'b10:   a_reg <= {S_r, a_reg[3:1]};
      default: a_reg <= a_reg;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [3:0] d, input logic [2:0] c);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = d;
    cmd_count = c;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic preload(input logic [3:0] d);
    issue(3'b000, d, 3'd0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    clear = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_data = '0; cmd_count = '0;
    serial_in = 1'b0;
    @(negedge clk);
    check("rst_s", s, 2'b11);
    check("rst_I", I, 4'h0);
    check("rst_fill", {S_l, S_r}, 2'b00);
    check("rst_busy_done_err", {busy, done, err}, 3'b000);
    @(negedge clk);
    clear = 1'b0;

    // 1: LOAD 1011
    issue(3'b000, 4'b1011, 3'd0);
    @(negedge clk);
    check("ld_s", s, 2'b00);
    check("ld_I", I, 4'b1011);
    check("ld_busy_rdy", {busy, cmd_ready}, 2'b10);
    @(negedge clk);
    check("ld_A", a_reg, 4'b1011);
    check("ld_done", {done, s}, 3'b111);
    @(negedge clk);
    check("ld_after", {done, cmd_ready}, 2'b01);

    // 2: SHL by 2 with fill 1 from 0001
    preload(4'b0001);
    serial_in = 1'b1;
    issue(3'b001, 4'h0, 3'd2);
    @(negedge clk);
    check("shl_c1", {s, S_l, S_r, a_reg}, {2'b01, 1'b1, 1'b0, 4'b0001});
    @(negedge clk);
    check("shl_c2", {s, S_l, S_r, a_reg, done}, {2'b01, 1'b1, 1'b0, 4'b0011, 1'b0});
    @(negedge clk);
    check("shl_done", {done, s, a_reg}, {1'b1, 2'b11, 4'b0111});
    serial_in = 1'b0;
    @(negedge clk);
    check("shl_idle", {done, cmd_ready}, 2'b01);

    // 3: ROTR by 4 from 1001 restores the word
    preload(4'b1001);
    issue(3'b100, 4'h0, 3'd4);
    @(negedge clk);
    check("rotr_c1", {s, S_r, S_l, a_reg}, {2'b10, 1'b1, 1'b0, 4'b1001});
    @(negedge clk);
    check("rotr_c2", {s, S_r, a_reg}, {2'b10, 1'b0, 4'b1100});
    @(negedge clk);
    check("rotr_c3", {s, S_r, a_reg}, {2'b10, 1'b0, 4'b0110});
    @(negedge clk);
    check("rotr_c4", {s, S_r, a_reg, done}, {2'b10, 1'b1, 4'b0011, 1'b0});
    @(negedge clk);
    check("rotr_done", {done, a_reg}, {1'b1, 4'b1001});
    @(negedge clk);
    check("rotr_once", done, 1'b0);

    // 4: zero-count SHR, then illegal opcode
    issue(3'b010, 4'h0, 3'd0);
    @(negedge clk);
    check("shr0_done", {done, s, busy}, {1'b1, 2'b11, 1'b0});
    @(negedge clk);
    check("shr0_A", {a_reg, done}, {4'b1001, 1'b0});
    issue(3'b110, 4'hF, 3'd3);
    @(negedge clk);
    check("ill_err", {err, done, cmd_ready, busy, s}, {1'b1, 1'b0, 1'b1, 1'b0, 2'b11});
    @(negedge clk);
    check("ill_clr", {err, done, a_reg}, {1'b0, 1'b0, 4'b1001});

    // 5: second command held valid during SHR by 2 is taken only once back in IDLE
    issue(3'b010, 4'h0, 3'd2);
    cmd_valid = 1'b1; cmd_op = 3'b011; cmd_count = 3'd1;
    @(negedge clk);
    check("bp_c1", {s, a_reg}, {2'b10, 4'b1001});
    @(negedge clk);
    check("bp_c2", {s, a_reg, cmd_ready}, {2'b10, 4'b0100, 1'b0});
    @(negedge clk);
    check("bp_done", {done, a_reg, cmd_ready}, {1'b1, 4'b0010, 1'b0});
    @(negedge clk);
    check("bp_rdy", {cmd_ready, s}, {1'b1, 2'b11});
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    check("bp_rotl", {s, S_l, busy, a_reg}, {2'b01, 1'b0, 1'b1, 4'b0010});
    @(negedge clk);
    check("bp_rotl_done", {done, a_reg}, {1'b1, 4'b0100});
    @(negedge clk);
    check("bp_once", {done, busy, s}, {1'b0, 1'b0, 2'b11});

    // 6: abort SHL by 7 after three shifts
    serial_in = 1'b1;
    issue(3'b001, 4'h0, 3'd7);
    repeat (3) @(negedge clk);
    check("ab_pre", {s, a_reg}, {2'b01, 4'b0011});
    @(negedge clk);
    check("ab_3shifts", {s, a_reg}, {2'b01, 4'b0111});
    clear = 1'b1;
    #1;
    check("ab_async", {s, busy, done}, {2'b11, 1'b0, 1'b0});
    @(negedge clk);
    check("ab_hold", {a_reg, done}, {4'b0111, 1'b0});
    clear = 1'b0;
    serial_in = 1'b0;
    @(negedge clk);
    check("ab_nodone", {done, cmd_ready}, 2'b01);
    issue(3'b000, 4'b0101, 3'd0);
    @(negedge clk);
    check("ab_ld_s", {s, I}, {2'b00, 4'b0101});
    @(negedge clk);
    check("ab_ld_done", {done, a_reg}, {1'b1, 4'b0101});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
